// File: rtl/stream_frame_sink_pkg.sv
// Shared types and state encoding for the stream frame sink.
package stream_frame_sink_pkg;

    localparam logic [1:0] SINK_IDLE = 2'd0;
    localparam logic [1:0] SINK_CAPT = 2'd1;
    localparam logic [1:0] SINK_FULL = 2'd2;

    // Network payload word: 24-bit mantissa field above an 8-bit exponent field.
    typedef struct packed {
        logic [23:0] mant;
        logic [7:0]  expo;
    } float_24_8_t;

    localparam int unsigned FLOAT_24_8_W = $bits(float_24_8_t);

endpackage

// File: rtl/stream_rdy_throttle.sv
// Periodic ready throttle: one slot every (stall_period+1) cycles.
module stream_rdy_throttle #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [CNT_W-1:0] i_stall_period,
    output logic             o_slot_ok
);

    logic [CNT_W-1:0] r_thr_cnt;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] w_thr_cnt_d;
    logic             w_wrap;

    // The period is latched at each wrap so a change only applies from the next wrap.
    assign w_wrap      = (r_thr_cnt == r_period);
    assign w_thr_cnt_d = w_wrap ? '0 : r_thr_cnt + CNT_W'(1);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_thr_cnt <= '0;
            r_period  <= '0;
        end else begin
            r_thr_cnt <= w_thr_cnt_d;
            if (w_wrap) begin
                r_period <= i_stall_period;
            end
        end
    end

    // Next-cycle slot, so the registered rdy in the parent lines up with thr_cnt==0.
    assign o_slot_ok = (w_thr_cnt_d == '0);

endmodule

// File: rtl/stream_frame_sink.sv
// Receive end of the vld/rdy/fst word stream: captures one frame, then serves host reads.
module stream_frame_sink
    import stream_frame_sink_pkg::*;
#(
    parameter int unsigned DATA_W    = FLOAT_24_8_W,
    parameter int unsigned FRAME_LEN = 36,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_in_data,
    input  logic              i_in_vld,
    input  logic              i_in_fst,
    output logic              o_in_rdy,
    input  logic [CNT_W-1:0]  i_stall_period,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_vld,
    input  logic              i_release,
    output logic              o_buf_full,
    output logic              o_frame_done,
    output logic [CNT_W-1:0]  o_frame_count,
    output logic              o_fst_err,
    output logic              o_sync_err,
    input  logic              i_err_clr
);

    localparam logic [ADDR_W-1:0] L_LAST_PTR = ADDR_W'(FRAME_LEN - 1);
    localparam logic [ADDR_W:0]   L_LEN      = (ADDR_W + 1)'(FRAME_LEN);

    logic [1:0]        r_state;
    logic [1:0]        w_state_d;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] w_wr_ptr_d;
    logic              r_in_rdy;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_frame_count;
    logic              r_fst_err;
    logic              r_sync_err;
    logic              r_rd_vld;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_mem [0:FRAME_LEN-1];

    logic              w_slot_ok;
    logic              w_acc;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic              w_done;
    logic              w_fst_set;
    logic              w_sync_set;
    logic              w_rd_in_range;

    stream_rdy_throttle #(
        .CNT_W (CNT_W)
    ) u_throttle (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_stall_period (i_stall_period),
        .o_slot_ok      (w_slot_ok)
    );

    assign w_acc = i_in_vld & r_in_rdy;

    always_comb begin
        w_state_d  = r_state;
        w_wr_ptr_d = r_wr_ptr;
        w_wr_en    = 1'b0;
        w_wr_addr  = r_wr_ptr;
        w_done     = 1'b0;
        w_fst_set  = 1'b0;
        w_sync_set = 1'b0;
        case (r_state)
            SINK_IDLE: begin
                if (w_acc) begin
                    if (i_in_fst) begin
                        w_wr_en    = 1'b1;
                        w_wr_addr  = '0;
                        w_wr_ptr_d = ADDR_W'(1);
                        w_state_d  = SINK_CAPT;
                    end else begin
                        w_sync_set = 1'b1;
                    end
                end
            end
            SINK_CAPT: begin
                if (w_acc) begin
                    w_wr_en = 1'b1;
                    if (i_in_fst) begin
                        // Resync on the new fst; the partial frame is abandoned.
                        w_fst_set  = 1'b1;
                        w_wr_addr  = '0;
                        w_wr_ptr_d = ADDR_W'(1);
                    end else if (r_wr_ptr == L_LAST_PTR) begin
                        w_wr_ptr_d = '0;
                        w_done     = 1'b1;
                        w_state_d  = SINK_FULL;
                    end else begin
                        w_wr_ptr_d = r_wr_ptr + ADDR_W'(1);
                    end
                end
            end
            SINK_FULL: begin
                if (i_release) begin
                    w_state_d = SINK_IDLE;
                end
            end
            default: begin
                w_state_d  = SINK_IDLE;
                w_wr_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state       <= SINK_IDLE;
            r_wr_ptr      <= '0;
            r_in_rdy      <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_fst_err     <= 1'b0;
            r_sync_err    <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_wr_ptr     <= w_wr_ptr_d;
            r_in_rdy     <= w_slot_ok & (w_state_d != SINK_FULL);
            r_frame_done <= w_done;
            if (w_done) begin
                r_frame_count <= r_frame_count + CNT_W'(1);
            end
            // A set in the same cycle as err_clr wins.
            if (w_fst_set) begin
                r_fst_err <= 1'b1;
            end else if (i_err_clr) begin
                r_fst_err <= 1'b0;
            end
            if (w_sync_set) begin
                r_sync_err <= 1'b1;
            end else if (i_err_clr) begin
                r_sync_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_in_data;
        end
    end

    assign w_rd_in_range = ({1'b0, i_rd_addr} < L_LEN);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_vld <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_rd_in_range ? r_mem[i_rd_addr] : '0;
            end
        end
    end

    assign o_in_rdy      = r_in_rdy;
    assign o_rd_data     = r_rd_data;
    assign o_rd_vld      = r_rd_vld;
    assign o_buf_full    = (r_state == SINK_FULL);
    assign o_frame_done  = r_frame_done;
    assign o_frame_count = r_frame_count;
    assign o_fst_err     = r_fst_err;
    assign o_sync_err    = r_sync_err;

endmodule
